mem_arb_subsys: RTL and testbench

Parametrised memory subsystem for the ARM-like CPU: one single-port word RAM shared between an instruction-fetch port and a data port. It uses round-robin arbitration, configurable wait-state latency, byte-enable writes and a ready handshake. It replaces the split, zero-latency instruction/data memories so a multi-cycle CPU can stall on memory.

---
 rtl/mem_arb_subsys_if.sv | 29 ++
 rtl/mem_arb_subsys.sv | 121 ++++++++++++
 tb/tb_mem_arb_subsys.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_subsys_if.sv
// Request/response bundle between the CPU-side requesters and the shared word RAM.
// The master side drives requests; the slave side returns data, ready pulses and busy.
interface mem_arb_subsys_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_ready;
  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ready;
  logic                  busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  i_rdata, i_ready, d_rdata, d_ready, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output i_rdata, i_ready, d_rdata, d_ready, busy
  );
endinterface

// File: rtl/mem_arb_subsys.sv
// Single-port word RAM shared by an instruction-fetch port and a data port,
// with round-robin arbitration, programmable wait states and byte-enable writes.
module mem_arb_subsys #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_arb_subsys_if.slave      bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state, stateNext;
  logic [2:0]          cnt, cntNext;
  logic                lastData;
  logic                pickData, takeReq, enterDone;
  logic                latData, latWe;
  logic [IDX_W-1:0]    latIdx;
  logic [BE_W-1:0]     latBe;
  logic [DATA_W-1:0]   latWdata;
  logic                accData, accWe;
  logic [IDX_W-1:0]    accIdx;
  logic [BE_W-1:0]     accBe;
  logic [DATA_W-1:0]   accWdata;
  logic [DATA_W-1:0]   ram [DEPTH];
  logic                unusedAddrBits;

  // Only the word-index bits of each address select a RAM word.
  assign unusedAddrBits = ^{bus.i_addr, bus.d_addr};

  // Data wins unless the instruction port also asks and data was served last.
  assign pickData = bus.d_req && (!bus.i_req || !lastData);
  assign takeReq  = (state == IDLE) && (bus.i_req || bus.d_req);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (takeReq) begin
          cntNext   = 3'(LATENCY);
          stateNext = (LATENCY > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        cntNext = cnt - 3'd1;
        if (cnt <= 3'd1) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // With zero wait states the access happens on the sampling edge itself,
  // so the access fields come straight from the bus while still in IDLE.
  always_comb begin
    if (state == IDLE) begin
      accData  = pickData;
      accWe    = pickData && bus.d_we;
      accIdx   = pickData ? bus.d_addr[IDX_W+1:2] : bus.i_addr[IDX_W+1:2];
      accBe    = bus.d_be;
      accWdata = bus.d_wdata;
    end else begin
      accData  = latData;
      accWe    = latWe;
      accIdx   = latIdx;
      accBe    = latBe;
      accWdata = latWdata;
    end
  end

  assign enterDone = !reset && (stateNext == DONE);
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lastData    <= 1'b0;
      latData     <= 1'b0;
      latWe       <= 1'b0;
      latIdx      <= '0;
      latBe       <= '0;
      latWdata    <= '0;
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      bus.i_ready <= enterDone && !accData;
      bus.d_ready <= enterDone && accData;
      if (takeReq) begin
        lastData <= pickData;
        latData  <= accData;
        latWe    <= accWe;
        latIdx   <= accIdx;
        latBe    <= accBe;
        latWdata <= accWdata;
      end
      if (enterDone && !accWe) begin
        if (accData) bus.d_rdata <= ram[accIdx];
        else         bus.i_rdata <= ram[accIdx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enterDone && accWe) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (accBe[b]) ram[accIdx][b*8 +: 8] <= accWdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_arb_subsys.sv
// Directed bench for mem_arb_subsys: three instances (LATENCY 2, 3, 0) share one
// stimulus bus, and sel routes requests to, and responses from, one instance at a time.
module tb_mem_arb_subsys;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int                 sel;
  logic               iReq, dReq, dWe;
  logic [AW-1:0]      iAddr, dAddr;
  logic [DW/8-1:0]    dBe;
  logic [DW-1:0]      dWdata;

  logic [2:0][DW-1:0] iRdataA, dRdataA;
  logic [2:0]         iReadyA, dReadyA, busyA;
  logic [DW-1:0]      iRdata, dRdata;
  logic               iReady, dReady, busy;

  int nChecks = 0;
  int nFails  = 0;

  for (genvar g = 0; g < 3; g++) begin : gInst
    mem_arb_subsys_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    assign bus.i_req   = iReq && (sel == g);
    assign bus.i_addr  = iAddr;
    assign bus.d_req   = dReq && (sel == g);
    assign bus.d_we    = dWe;
    assign bus.d_be    = dBe;
    assign bus.d_addr  = dAddr;
    assign bus.d_wdata = dWdata;
    assign iRdataA[g]  = bus.i_rdata;
    assign dRdataA[g]  = bus.d_rdata;
    assign iReadyA[g]  = bus.i_ready;
    assign dReadyA[g]  = bus.d_ready;
    assign busyA[g]    = bus.busy;

    mem_arb_subsys #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .DEPTH  (64),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 3 : 0))
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  assign iRdata = iRdataA[sel];
  assign dRdata = dRdataA[sel];
  assign iReady = iReadyA[sel];
  assign dReady = dReadyA[sel];
  assign busy   = busyA[sel];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for the selected instance to be idle, issues one request, and returns
  // the 1-based cycle (counting the sampling cycle as 1) in which ready was seen.
  task automatic doAccess(input bit isData, input bit we, input logic [AW-1:0] addr,
                          input logic [3:0] be, input logic [DW-1:0] wd, output int cycles);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (isData) begin
      dReq = 1'b1; dWe = we; dAddr = addr; dBe = be; dWdata = wd;
    end else begin
      iReq = 1'b1; iAddr = addr;
    end
    cycles = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      cycles++;
    end while (!(isData ? dReady : iReady) && cycles < 20);
    iReq = 1'b0;
    dReq = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) checkVal("readyExclusive", {31'b0, iReady & dReady}, 32'h0);
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int stuck;
    logic [DW-1:0] expIR [4];
    logic [31:0]   expGrant [4];

    reset = 1'b1; sel = 0;
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    iAddr = '0; dAddr = '0; dBe = '0; dWdata = '0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkVal("rstBusy",   {31'b0, busy},   32'h0);
      checkVal("rstIReady", {31'b0, iReady}, 32'h0);
      checkVal("rstDReady", {31'b0, dReady}, 32'h0);
      checkVal("rstIRdata", iRdata, 32'h0);
      checkVal("rstDRdata", dRdata, 32'h0);
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // LATENCY=2: write then read
    doAccess(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, cyc);
    checkVal("l2WriteLat", 32'(cyc), 32'd3);
    doAccess(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, cyc);
    checkVal("l2ReadLat",  32'(cyc), 32'd3);
    checkVal("l2ReadData", dRdata, 32'hDEADBEEF);
    checkVal("l2IRdataHeld", iRdata, 32'h0);

    // Byte enables, including an all-zero enable write
    doAccess(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344, cyc);
    doAccess(1'b1, 1'b1, 32'h20, 4'b0100, 32'hAABBCCDD, cyc);
    checkVal("beWriteLat", 32'(cyc), 32'd3);
    doAccess(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, cyc);
    checkVal("beMerge", dRdata, 32'h11BB3344);
    doAccess(1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, cyc);
    checkVal("beZeroReady", 32'(cyc), 32'd3);
    checkVal("writeHoldsRdata", dRdata, 32'h11BB3344);
    doAccess(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, cyc);
    checkVal("beZeroNoChange", dRdata, 32'h11BB3344);

    // Aliasing modulo DEPTH*4 bytes and ignored low address bits
    doAccess(1'b1, 1'b1, 32'h000, 4'hF, 32'hCAFEF00D, cyc);
    doAccess(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, cyc);
    checkVal("alias100", dRdata, 32'hCAFEF00D);
    doAccess(1'b1, 1'b0, 32'h003, 4'h0, 32'h0, cyc);
    checkVal("alias003", dRdata, 32'hCAFEF00D);

    // Arbitration after reset with both ports requesting continuously
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expGrant = '{32'd1, 32'd0, 32'd1, 32'd0};
    expIR    = '{32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    iAddr = 32'h10; dAddr = 32'h20; dWe = 1'b0; dBe = '0;
    iReq = 1'b1; dReq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(iReady || dReady) && cyc < 20);
      checkVal($sformatf("arbGrant%0d", k), dReady ? 32'd1 : (iReady ? 32'd0 : 32'd2), expGrant[k]);
      checkVal($sformatf("arbIRdata%0d", k), iRdata, expIR[k]);
      checkVal($sformatf("arbDRdata%0d", k), dRdata, 32'h11BB3344);
    end
    iReq = 1'b0; dReq = 1'b0;

    // LATENCY=3: reset during WAIT discards the pending write
    sel = 1;
    @(negedge clk);
    doAccess(1'b1, 1'b1, 32'h30, 4'hF, 32'h0, cyc);
    checkVal("l3WriteLat", 32'(cyc), 32'd4);
    @(negedge clk);
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h30; dBe = 4'hF; dWdata = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    checkVal("rstWaitBusyBefore", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    dReq = 1'b0;
    @(negedge clk);
    checkVal("rstWaitBusy",   {31'b0, busy},   32'h0);
    checkVal("rstWaitDReady", {31'b0, dReady}, 32'h0);
    reset = 1'b0;
    stuck = 0;
    repeat (6) begin
      @(negedge clk);
      if (dReady) stuck = 1;
    end
    checkVal("rstWaitNoReady", 32'(stuck), 32'd0);
    doAccess(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, cyc);
    checkVal("l3ReadLat", 32'(cyc), 32'd4);
    checkVal("rstWaitDiscard", dRdata, 32'h0);

    // LATENCY=0: fetch completes in the sampling cycle, busy for one cycle
    sel = 2;
    @(negedge clk);
    doAccess(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, cyc);
    checkVal("l0WriteLat", 32'(cyc), 32'd1);
    @(negedge clk);
    checkVal("l0IdleBefore", {31'b0, busy}, 32'h0);
    doAccess(1'b0, 1'b0, 32'h10, 4'h0, 32'h0, cyc);
    checkVal("l0FetchLat",  32'(cyc), 32'd1);
    checkVal("l0FetchData", iRdata, 32'hDEADBEEF);
    checkVal("l0BusyDone",  {31'b0, busy}, 32'h1);
    @(negedge clk);
    checkVal("l0BusyAfter", {31'b0, busy}, 32'h0);
    checkVal("l0ReadyPulse", {31'b0, iReady}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
